// File: rtl/minmax_tracker.sv
// Signed running min/max/count over a valid/ready packet; one registered result per packet.
// Latency: result valid on the edge that accepts the last beat; one idle cycle after each result handshake.
// Backpressure: in_ready drops while a result waits; it depends on state only, never on out_ready.

// Signed less-than: sign-extend both operands by one bit, subtract, and take the
// sign of the (N+1)-bit difference. The extra bit keeps the difference exact,
// so opposite-sign extremes compare correctly.
module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    logic [N:0] diff;

    assign diff = {a[N-1], a} - {b[N-1], b};
    assign lt   = diff[N];
endmodule

module minmax_tracker #(
    parameter int N       = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_min,
    output logic [N-1:0]       out_max,
    output logic [COUNT_W-1:0] out_count
);
    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t             state;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [N-1:0]       min_q;
    logic [N-1:0]       max_q;
    logic [COUNT_W-1:0] count_q;

    logic               accept;
    logic               new_is_min;
    logic               new_is_max;
    logic               count_sat;

    // New sample strictly below the running minimum
    slt #(.N(N)) u_slt_min (
        .a  (in_data),
        .b  (min_q),
        .lt (new_is_min)
    );

    // Running maximum strictly below the new sample
    slt #(.N(N)) u_slt_max (
        .a  (max_q),
        .b  (in_data),
        .lt (new_is_max)
    );

    assign accept    = in_valid && in_ready_q;
    assign count_sat = (count_q == {COUNT_W{1'b1}});

    // Packet FSM: accumulator registers double as the result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        min_q   <= in_data;
                        max_q   <= in_data;
                        count_q <= COUNT_W'(1);
                        if (in_last) begin
                            state       <= S_OUTPUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (new_is_min) begin
                            min_q <= in_data;
                        end
                        if (new_is_max) begin
                            max_q <= in_data;
                        end
                        if (!count_sat) begin
                            count_q <= count_q + COUNT_W'(1);
                        end
                        if (in_last) begin
                            state       <= S_OUTPUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_OUTPUT: begin
                    // Input reopens only the cycle after the result is taken
                    if (out_ready) begin
                        state       <= S_EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;
endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Streaming reduction stage that sits directly downstream of the signed `slt` comparator.
- Accepts a packet of signed two's-complement N-bit samples over a valid/ready handshake.
- Tracks the running minimum, running maximum and sample count; presents them as one registered result when the packet's last beat is accepted.
- All magnitude decisions come from two instances of the team's structural `slt` comparator (parameter N); no behavioural `<`/`>` on data.

Parameters:
- N, 32, data width in bits; samples are signed two's complement.
- COUNT_W, 16, width of the sample counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a sample on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  N  signed sample.
- in_last  input  1  qualifies in_data as the final sample of the packet.
- out_valid  output  1  result registers hold a complete packet result.
- out_ready  input  1  downstream consumes the result.
- out_min  output  N  signed minimum of the packet.
- out_max  output  N  signed maximum of the packet.
- out_count  output  COUNT_W  number of samples in the packet (saturating).

Behaviour:
- Handshakes:
  - Input beat accepted iff in_valid && in_ready at a rising edge.
  - Output beat consumed iff out_valid && out_ready at a rising edge.
  - in_data and in_last are ignored when not accepted.
- States:
  - S_EMPTY: no samples held for the current packet.
  - S_ACCUM: at least one sample held, last not yet seen.
  - S_OUTPUT: result valid, waiting on downstream.
- in_ready = 1 in S_EMPTY and S_ACCUM; 0 in S_OUTPUT. It is a pure function of state, with no combinational path from out_ready.
- out_valid = 1 only in S_OUTPUT.
- Reset (rst=1 at an edge, any state, including mid-packet or while out_valid):
  - state = S_EMPTY.
  - out_min = 0, out_max = 0, out_count = 0, out_valid = 0.
  - Any partial packet is discarded.
- Transitions:
  - S_EMPTY + accepted beat:
    - min = max = in_data; count = 1.
    - Next state is S_OUTPUT if in_last, else S_ACCUM.
  - S_ACCUM + accepted beat:
    - min = in_data if slt(in_data, min) = 1.
    - max = in_data if slt(max, in_data) = 1.
    - count increments, saturating at 2^COUNT_W-1.
    - Next state is S_OUTPUT if in_last, else stays S_ACCUM.
  - S_OUTPUT + out_ready: next state is S_EMPTY. in_ready rises the cycle after the handshake; no input is accepted in the same cycle as the output handshake.
  - S_OUTPUT without out_ready: hold. out_min, out_max and out_count remain stable.
  - No accepted beat in S_EMPTY or S_ACCUM: hold.
- Timing and registers:
  - Latency: out_valid asserts on the edge that accepts the last beat, so it is visible the cycle after that beat's valid cycle.
  - The accumulator registers drive out_min, out_max and out_count directly; no separate output copy.
  - Mid-packet values on those ports are don't-care to the bench; only values while out_valid=1 are checked.
- Equal values: no update (strict compare). Result values are unaffected.
- The comparison must be correct across the full signed range, including opposite-sign extremes (-2^(N-1) vs 2^(N-1)-1).
- Throughput: one sample per cycle while accumulating. One idle cycle per packet after the output handshake.

Test Plan:
- Reset, then the packet {5, -3, 12, 0 (last)}, out_ready=1 → out_valid one cycle after last beat; min=-3, max=12, count=4; in_ready=1 the following cycle.
- Single-beat packet {-7 (last)} → out_valid next cycle; min=max=-7, count=1.
- Overflow extremes, N=32: {0x7FFFFFFF, 0x80000000 (last)} → min=0x80000000, max=0x7FFFFFFF, count=2.
- Backpressure: result ready with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, outputs stable, no beat consumed; out_ready=1 → S_EMPTY, next packet accepted afterward.
- Reset mid-packet: send {100, 200}, assert rst one cycle, then send {1 (last)} → min=max=1, count=1; no trace of 100/200.
- Duplicates and gaps: {4, 4, 4 (last)} with in_valid dropped between beats → min=max=4, count=3; idle cycles do not change count.
